// File: rtl/fixed_pkg.sv
// Shared definitions for the fixed-point MAC datapath: result-word width,
// FIFO entry layout and level-counter width helpers.
package fixed_pkg;

  localparam int DEF_WIO = 15;
  localparam int DEF_WFO = 30;

  function automatic int result_w(input int wio, input int wfo);
    return wio + wfo;
  endfunction

  // One extra bit so a completely full FIFO (level == DEPTH) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_W       = result_w(DEF_WIO, DEF_WFO);
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_LEVEL_W = level_w(DEF_DEPTH);

  typedef struct packed {
    logic             last;
    logic             of;
    logic             uf;
    logic [DEF_W-1:0] data;
  } result_entry_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array with a single synchronous write port and an
// asynchronous read port; no reset, contents are qualified by the owner.
module sync_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 48
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mac_result_fifo.sv
// First-word-fall-through result buffer behind fixed_mac, with saturating
// overflow / underflow / frame event counters.
module mac_result_fifo
  import fixed_pkg::*;
#(
  parameter int WIO   = 15,
  parameter int WFO   = 30,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIO+WFO-1:0]       in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  output logic [WIO+WFO-1:0]       out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     out_overflow,
  output logic                     out_underflow,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  input  logic                     clear_counts,
  output logic [CNT_W-1:0]         of_count,
  output logic [CNT_W-1:0]         uf_count,
  output logic [CNT_W-1:0]         frame_count
);

  localparam int W  = result_w(WIO, WFO);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);
  localparam int EW = W + 3;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             in_ready_q, in_ready_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [CNT_W-1:0] of_count_q, of_count_d;
  logic [CNT_W-1:0] uf_count_q, uf_count_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;

  logic          push;
  logic          pop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  // A clear that coincides with an event keeps that event, so it loads 1.
  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] cnt,
                                                  input logic             inc,
                                                  input logic             clr);
    logic [CNT_W-1:0] res;
    if (inc) begin
      if (clr) begin
        res = CNT_W'(1);
      end else if (&cnt) begin
        res = cnt;
      end else begin
        res = cnt + CNT_W'(1);
      end
    end else begin
      res = clr ? '0 : cnt;
    end
    return res;
  endfunction

  assign push     = in_valid && in_ready_q;
  assign pop      = !empty_q && out_ready;
  assign wr_entry = {in_last, in_overflow, in_underflow, in_data};

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d       = level_q + LW'(push) - LW'(pop);
    // Registered ready: a pop while full frees a slot only from the next cycle.
    in_ready_d    = level_d < LW'(DEPTH);
    full_d        = level_d == LW'(DEPTH);
    empty_d       = level_d == '0;
    of_count_d    = count_next(of_count_q,    push && in_overflow,  clear_counts);
    uf_count_d    = count_next(uf_count_q,    push && in_underflow, clear_counts);
    frame_count_d = count_next(frame_count_q, push && in_last,      clear_counts);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      in_ready_q    <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      of_count_q    <= '0;
      uf_count_q    <= '0;
      frame_count_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      in_ready_q    <= in_ready_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      of_count_q    <= of_count_d;
      uf_count_q    <= uf_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Stale memory contents are masked so an empty FIFO always presents zeros.
  assign out_valid     = !empty_q;
  assign out_data      = empty_q ? '0   : rd_entry[W-1:0];
  assign out_underflow = empty_q ? 1'b0 : rd_entry[W];
  assign out_overflow  = empty_q ? 1'b0 : rd_entry[W+1];
  assign out_last      = empty_q ? 1'b0 : rd_entry[W+2];

  assign in_ready    = in_ready_q;
  assign level       = level_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign of_count    = of_count_q;
  assign uf_count    = uf_count_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mac_result_fifo.sv
// Scoreboard bench for mac_result_fifo; a second instance with 4-bit
// counters shares the stimulus to exercise counter saturation.
module tb_mac_result_fifo;
  import fixed_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [44:0] in_data;
  logic        in_valid, in_last, in_overflow, in_underflow;
  logic        out_ready, clear_counts;

  logic        in_ready, out_valid, out_last, out_overflow, out_underflow;
  logic [44:0] out_data;
  logic [3:0]  level;
  logic        full, empty;
  logic [15:0] of_count, uf_count, frame_count;

  logic        s_in_ready, s_out_valid, s_out_last, s_out_overflow, s_out_underflow;
  logic [44:0] s_out_data;
  logic [3:0]  s_level;
  logic        s_full, s_empty;
  logic [3:0]  s_of_count, s_uf_count, s_frame_count;

  int passed = 0;
  int checks = 0;

  result_entry_t sb[$];
  result_entry_t obs, exp;
  logic          did_push, did_pop;

  always #5 clk = ~clk;

  mac_result_fifo #(.WIO(15), .WFO(30), .DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_overflow(in_overflow),
    .in_underflow(in_underflow), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .level(level), .full(full), .empty(empty),
    .clear_counts(clear_counts), .of_count(of_count), .uf_count(uf_count),
    .frame_count(frame_count)
  );

  mac_result_fifo #(.WIO(15), .WFO(30), .DEPTH(8), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_last(in_last), .in_overflow(in_overflow),
    .in_underflow(in_underflow), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_last(s_out_last), .out_overflow(s_out_overflow),
    .out_underflow(s_out_underflow), .level(s_level), .full(s_full), .empty(s_empty),
    .clear_counts(clear_counts), .of_count(s_of_count), .uf_count(s_uf_count),
    .frame_count(s_frame_count)
  );

  // Records the handshake seen just before the edge, then advances one cycle.
  task automatic tick();
    did_push = in_valid && in_ready && !reset;
    did_pop  = out_valid && out_ready && !reset;
    obs      = {out_last, out_overflow, out_underflow, out_data};
    if (did_push) sb.push_back({in_last, in_overflow, in_underflow, in_data});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_counts = 1'b0;
    in_last = 1'b0; in_overflow = 1'b0; in_underflow = 1'b0; in_data = '0;
    tick();
    reset = 1'b0;
    tick();
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_counts = 1'b0;
    in_last = 1'b0; in_overflow = 1'b0; in_underflow = 1'b0; in_data = '0;
    tick();
    checks++;
    if ({in_ready, out_valid, full, empty, level} !== {1'b0, 1'b0, 1'b0, 1'b1, 4'd0})
      $display("[TB] FAIL reset_flags: got rdy/vld/full/empty/level %b %b %b %b %0d want 0 0 0 1 0",
               in_ready, out_valid, full, empty, level);
    else passed++;
    checks++;
    if ({out_data, out_last, out_overflow, out_underflow} !== 48'd0)
      $display("[TB] FAIL reset_outputs: got data %h flags %b%b%b want all zero",
               out_data, out_last, out_overflow, out_underflow);
    else passed++;
    checks++;
    if ({of_count, uf_count, frame_count} !== 48'd0)
      $display("[TB] FAIL reset_counts: got %0d %0d %0d want 0 0 0", of_count, uf_count, frame_count);
    else passed++;
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL ready_after_reset: got %b want 1", in_ready);
    else passed++;
    sb.delete();
  endtask

  task automatic test_basic();
    do_reset();
    in_valid = 1'b1; in_data = 45'h1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 45'h1)
      $display("[TB] FAIL first_latency: got valid %b data %h want 1 1", out_valid, out_data);
    else passed++;
    in_data = 45'h2; tick();
    in_data = 45'h3; tick();
    in_valid = 1'b0;
    checks++;
    if (level !== 4'd3 || out_data !== 45'h1)
      $display("[TB] FAIL three_push: got level %0d data %h want 3 1", level, out_data);
    else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (did_pop) begin
        checks++;
        if (sb.size() == 0) $display("[TB] FAIL basic_order: got pop want no pop (scoreboard empty)");
        else begin
          exp = sb.pop_front();
          if (obs !== exp) $display("[TB] FAIL basic_order: got %h want %h", obs, exp);
          else passed++;
        end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || sb.size() != 0)
      $display("[TB] FAIL basic_drain: got empty %b leftover %0d want 1 0", empty, sb.size());
    else passed++;
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 45'h10 + 45'(i);
      tick();
    end
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || level !== 4'd8)
      $display("[TB] FAIL full_flags: got full %b ready %b level %0d want 1 0 8", full, in_ready, level);
    else passed++;
    in_data = 45'h99;
    tick();
    checks++;
    if (level !== 4'd8 || out_data !== 45'h10)
      $display("[TB] FAIL held_word: got level %0d head %h want 8 10", level, out_data);
    else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (did_pop) begin
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) $display("[TB] FAIL full_pop: got %h want %h", obs, exp);
      else passed++;
    end
    checks++;
    if (in_ready !== 1'b1 || level !== 4'd7)
      $display("[TB] FAIL pop_while_full: got ready %b level %0d want 1 7", in_ready, level);
    else passed++;
    tick();
    in_valid = 1'b0;
    checks++;
    if (level !== 4'd8 || full !== 1'b1)
      $display("[TB] FAIL ninth_accept: got level %0d full %b want 8 1", level, full);
    else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (did_pop) begin
        checks++;
        if (sb.size() == 0) $display("[TB] FAIL full_order: got pop want no pop (scoreboard empty)");
        else begin
          exp = sb.pop_front();
          if (obs !== exp) $display("[TB] FAIL full_order: got %h want %h", obs, exp);
          else passed++;
        end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || sb.size() != 0)
      $display("[TB] FAIL full_drain: got empty %b leftover %0d want 1 0", empty, sb.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data      = {13'($urandom), $urandom};
      in_last      = 1'($urandom);
      in_overflow  = 1'($urandom);
      in_underflow = 1'($urandom);
      tick();
      if (did_pop) begin
        pops++;
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) $display("[TB] FAIL stream_order: word %0d got %h want %h", pops, obs, exp);
        else passed++;
      end
      checks++;
      if (level !== 4'd1) $display("[TB] FAIL stream_level: cycle %0d got %0d want 1", i, level);
      else passed++;
    end
    in_valid = 1'b0;
    tick();
    if (did_pop) begin
      pops++;
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) $display("[TB] FAIL stream_order: word %0d got %h want %h", pops, obs, exp);
      else passed++;
    end
    out_ready = 1'b0;
    checks++;
    if (pops != 20 || level !== 4'd0)
      $display("[TB] FAIL stream_count: got pops %0d level %0d want 20 0", pops, level);
    else passed++;
  endtask

  task automatic test_counters();
    logic [4:0] of_pat   = 5'b00011;
    logic [4:0] uf_pat   = 5'b00100;
    logic [4:0] last_pat = 5'b01010;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data      = 45'h100 + 45'(i);
      in_overflow  = of_pat[i];
      in_underflow = uf_pat[i];
      in_last      = last_pat[i];
      tick();
    end
    in_valid = 1'b0; in_overflow = 1'b0; in_underflow = 1'b0; in_last = 1'b0;
    checks++;
    if (of_count !== 16'd2 || uf_count !== 16'd1 || frame_count !== 16'd2)
      $display("[TB] FAIL event_counts: got %0d %0d %0d want 2 1 2", of_count, uf_count, frame_count);
    else passed++;
    clear_counts = 1'b1; in_valid = 1'b1; in_overflow = 1'b1;
    tick();
    clear_counts = 1'b0; in_valid = 1'b0; in_overflow = 1'b0;
    checks++;
    if (of_count !== 16'd1 || uf_count !== 16'd0 || frame_count !== 16'd0)
      $display("[TB] FAIL clear_with_inc: got %0d %0d %0d want 1 0 0", of_count, uf_count, frame_count);
    else passed++;
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    checks++;
    if (of_count !== 16'd0 || s_of_count !== 4'd0)
      $display("[TB] FAIL clear_alone: got %0d %0d want 0 0", of_count, s_of_count);
    else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_overflow = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 45'h200 + 45'(i);
      tick();
      if (did_pop) begin
        exp = sb.pop_front();
        checks++;
        if (obs !== exp) $display("[TB] FAIL sat_order: got %h want %h", obs, exp);
        else passed++;
      end
    end
    in_valid = 1'b0; in_overflow = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++;
    if (s_of_count !== 4'hF) $display("[TB] FAIL of_saturate: got %0d want 15", s_of_count);
    else passed++;
    checks++;
    if (of_count !== 16'd17) $display("[TB] FAIL of_wide: got %0d want 17", of_count);
    else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 45'h300 + 45'(i);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (level !== 4'd4 || frame_count !== 16'd4)
      $display("[TB] FAIL fill_four: got level %0d frames %0d want 4 4", level, frame_count);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    checks++;
    if (level !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || frame_count !== 16'd0)
      $display("[TB] FAIL mid_reset: got level %0d valid %b ready %b frames %0d want 0 0 0 0",
               level, out_valid, in_ready, frame_count);
    else passed++;
    tick();
    checks++;
    if (in_ready !== 1'b1 || empty !== 1'b1)
      $display("[TB] FAIL mid_release: got ready %b empty %b want 1 1", in_ready, empty);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_counters();
    test_saturation();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
